// File: rtl/commit_trace_buffer_pkg.sv
// Shared types for the commit trace buffer: FSM state encoding and the packed trace entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: trace_state_e (IDLE/ARMED/CAPTURE/DONE), trace_entry_t {pc, instr, rd, we, wdata},
//   STATE_W state width, TRACE_XLEN datapath width of the RV32I core.
package trace_pkg;

  // The tracer sits on an RV32I core, so the entry datapath is fixed at 32 bits.
  localparam int TRACE_XLEN = 32;
  localparam int STATE_W    = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_e;

  typedef struct packed {
    logic [TRACE_XLEN-1:0] pc;
    logic [31:0]           instr;
    logic [4:0]            rd;
    logic                  we;
    logic [TRACE_XLEN-1:0] wdata;
  } trace_entry_t;

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Commit-side input bus and trace read-out port of the commit trace buffer.
// Latency: n/a (wires only).
// Backpressure: read port is valid/ready; the commit side has none (commits are never stalled).
// master: drives commit_* and rd_ready, receives rd_*. slave: the trace buffer.
interface commit_trace_buffer_if
  import trace_pkg::*;
#(
  parameter int XLEN = TRACE_XLEN
);
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic [31:0]     commit_instr;
  logic [4:0]      commit_rd;
  logic            commit_we;
  logic [XLEN-1:0] commit_wdata;

  logic            rd_valid;
  logic            rd_ready;
  logic [XLEN-1:0] rd_pc;
  logic [31:0]     rd_instr;
  logic [4:0]      rd_rd;
  logic            rd_we;
  logic [XLEN-1:0] rd_wdata;

  modport master (
    output commit_valid, commit_pc, commit_instr, commit_rd, commit_we, commit_wdata,
    output rd_ready,
    input  rd_valid, rd_pc, rd_instr, rd_rd, rd_we, rd_wdata
  );

  modport slave (
    input  commit_valid, commit_pc, commit_instr, commit_rd, commit_we, commit_wdata,
    input  rd_ready,
    output rd_valid, rd_pc, rd_instr, rd_rd, rd_we, rd_wdata
  );
endinterface

// File: rtl/commit_trace_buffer_ring.sv
// Ring storage for trace entries with read/write pointers and an occupancy count.
// Latency: a push is visible on rd_entry/count the cycle after the write edge; rd_entry is combinational.
// Backpressure: none internally; the owner decides push vs push_overwrite vs drop when full.
// Ports: clk, reset_n; clear (pointers/count to 0, wins over everything); push (normal write),
//   push_overwrite (write while full, discarding the oldest), pop; wr_entry in; rd_entry, count, full, empty out.
module trace_ring
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     push_overwrite,
  input  logic                     pop,
  input  trace_entry_t             wr_entry,
  output trace_entry_t             rd_entry,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en;

  // Storage holds no state that needs a reset: count gates visibility.
  trace_entry_t mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_en    = 1'b0;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_en = push | push_overwrite;
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      // An overwrite consumes the oldest slot, so the read side advances with it.
      if (pop | push_overwrite) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      // Overwrite keeps occupancy at DEPTH; push+pop cancel out.
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign rd_entry = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);

endmodule

// File: rtl/commit_trace_buffer.sv
// Retire tracer: records one entry per committed instruction into a ring, with PC trigger and post-trigger depth.
// Latency: a commit is visible on rd_* / count one cycle after its edge; rd_* are combinational from storage.
// Backpressure: commits are never stalled; when full, CAPTURE overwrites (WRAP=1) or drops (WRAP=0), ARMED always overwrites.
// Ports: clk, reset_n (async, active low); bus (commit_* in, rd_* valid/ready out);
//   arm/stop pulses, trig_en/trig_pc/post_count session setup; count, overflow (sticky), state status.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int XLEN  = TRACE_XLEN,  // entry layout is fixed at TRACE_XLEN; keep these equal
  parameter int DEPTH = 16,          // power of two, >= 2
  parameter int WRAP  = 1            // 1: overwrite oldest when full in CAPTURE, 0: stop at full
) (
  input  logic                      clk,
  input  logic                      reset_n,
  commit_trace_buffer_if.slave      bus,
  input  logic                      arm,
  input  logic                      stop,
  input  logic                      trig_en,
  input  logic [XLEN-1:0]           trig_pc,
  input  logic [$clog2(DEPTH):0]    post_count,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic [STATE_W-1:0]        state
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  trace_state_e     state_q, state_d;
  logic             trig_en_q, trig_en_d;
  logic [CNT_W-1:0] post_q, post_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             overflow_q, overflow_d;

  logic             ring_clear, ring_push, ring_ovw, ring_pop;
  logic             ring_full, ring_empty;
  logic [CNT_W-1:0] ring_count;
  logic             live, wrote;
  trace_entry_t     wr_entry, rd_entry;

  assign wr_entry = '{pc:    bus.commit_pc,
                      instr: bus.commit_instr,
                      rd:    bus.commit_rd,
                      we:    bus.commit_we,
                      wdata: bus.commit_wdata};

  assign live = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);

  always_comb begin
    state_d     = state_q;
    trig_en_d   = trig_en_q;
    post_d      = post_q;
    remaining_d = remaining_q;
    overflow_d  = overflow_q;
    ring_clear  = 1'b0;
    ring_push   = 1'b0;
    ring_ovw    = 1'b0;
    ring_pop    = 1'b0;
    wrote       = 1'b0;

    if (arm) begin
      // arm wipes the session; a commit, pop or stop in the same cycle is discarded.
      ring_clear  = 1'b1;
      overflow_d  = 1'b0;
      trig_en_d   = trig_en;
      post_d      = post_count;
      remaining_d = post_count;
      state_d     = trig_en ? ST_ARMED : ST_CAPTURE;
    end else begin
      ring_pop = !ring_empty && bus.rd_ready;

      if (bus.commit_valid && live) begin
        if (!ring_full || ring_pop) begin
          // A concurrent pop frees a slot, so a full buffer still takes a plain push.
          ring_push = 1'b1;
        end else if (state_q == ST_ARMED || WRAP != 0) begin
          ring_ovw = 1'b1;
          // Losing pre-trigger history is expected and not reported.
          if (state_q == ST_CAPTURE) begin
            overflow_d = 1'b1;
          end
        end else begin
          overflow_d = 1'b1;
          // Untriggered stop-at-full session ends on the first dropped commit.
          if (!trig_en_q) begin
            state_d = ST_DONE;
          end
        end
        wrote = ring_push | ring_ovw;

        if (state_q == ST_ARMED) begin
          if (bus.commit_pc == trig_pc) begin
            remaining_d = post_q;
            state_d     = (post_q == '0) ? ST_DONE : ST_CAPTURE;
          end
        end else if (trig_en_q && wrote) begin
          // Dropped commits do not count toward the post-trigger depth.
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end

      if (stop && live) begin
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      trig_en_q   <= 1'b0;
      post_q      <= '0;
      remaining_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_en_q   <= trig_en_d;
      post_q      <= post_d;
      remaining_q <= remaining_d;
      overflow_q  <= overflow_d;
    end
  end

  trace_ring #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk            (clk),
    .reset_n        (reset_n),
    .clear          (ring_clear),
    .push           (ring_push),
    .push_overwrite (ring_ovw),
    .pop            (ring_pop),
    .wr_entry       (wr_entry),
    .rd_entry       (rd_entry),
    .count          (ring_count),
    .full           (ring_full),
    .empty          (ring_empty)
  );

  assign bus.rd_valid = !ring_empty;
  assign bus.rd_pc    = rd_entry.pc;
  assign bus.rd_instr = rd_entry.instr;
  assign bus.rd_rd    = rd_entry.rd;
  assign bus.rd_we    = rd_entry.we;
  assign bus.rd_wdata = rd_entry.wdata;

  assign count    = ring_count;
  assign overflow = overflow_q;
  assign state    = state_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: a WRAP=1 and a WRAP=0 instance share one stimulus stream.
// Latency: n/a.
// Backpressure: rd_ready driven randomly / by directed pops.
module tb_commit_trace_buffer;
  import trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int CW    = 5;
  localparam int S_IDLE = 0, S_ARMED = 1, S_CAPTURE = 2, S_DONE = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic commit_valid = 1'b0;
  logic [31:0] commit_pc = '0, commit_instr = '0, commit_wdata = '0;
  logic [4:0] commit_rd = '0;
  logic commit_we = 1'b0;
  logic rd_ready = 1'b0, arm = 1'b0, stop = 1'b0, trig_en = 1'b0;
  logic [31:0] trig_pc = '0;
  logic [CW-1:0] post_count = '0;

  logic [CW-1:0] count_w, count_s;
  logic ovf_w, ovf_s;
  logic [1:0] st_w, st_s;

  always #5 clk = ~clk;

  commit_trace_buffer_if #(.XLEN(32)) bw ();
  commit_trace_buffer_if #(.XLEN(32)) bs ();

  assign bw.commit_valid = commit_valid;  assign bs.commit_valid = commit_valid;
  assign bw.commit_pc    = commit_pc;     assign bs.commit_pc    = commit_pc;
  assign bw.commit_instr = commit_instr;  assign bs.commit_instr = commit_instr;
  assign bw.commit_rd    = commit_rd;     assign bs.commit_rd    = commit_rd;
  assign bw.commit_we    = commit_we;     assign bs.commit_we    = commit_we;
  assign bw.commit_wdata = commit_wdata;  assign bs.commit_wdata = commit_wdata;
  assign bw.rd_ready     = rd_ready;      assign bs.rd_ready     = rd_ready;

  commit_trace_buffer #(.XLEN(32), .DEPTH(DEPTH), .WRAP(1)) u_wrap (
    .clk(clk), .reset_n(reset_n), .bus(bw), .arm(arm), .stop(stop), .trig_en(trig_en),
    .trig_pc(trig_pc), .post_count(post_count), .count(count_w), .overflow(ovf_w), .state(st_w));

  commit_trace_buffer #(.XLEN(32), .DEPTH(DEPTH), .WRAP(0)) u_stop (
    .clk(clk), .reset_n(reset_n), .bus(bs), .arm(arm), .stop(stop), .trig_en(trig_en),
    .trig_pc(trig_pc), .post_count(post_count), .count(count_s), .overflow(ovf_s), .state(st_s));

  // ---------------- reference model: one queue of entries per instance ----------------
  trace_entry_t mq [2][$];
  int m_state [2];
  bit m_ten [2];
  int m_post [2];
  int m_rem [2];
  bit m_ovf [2];

  int n_chk = 0, n_pass = 0;
  bit cmp_en = 1'b0;

  task automatic check(string name, int w, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (%s) got=%0h expected=%0h t=%0t", name, (w != 0) ? "wrap0" : "wrap1", act, exp, $time);
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      mq[w].delete();
      m_state[w] = S_IDLE; m_ten[w] = 1'b0; m_post[w] = 0; m_rem[w] = 0; m_ovf[w] = 1'b0;
    end
  endtask

  // One clock edge of the specified behaviour, evaluated on the inputs present at that edge.
  task automatic model_step(int w, bit wrap);
    trace_entry_t e;
    bit live, wrote;
    int nst;
    if (arm) begin
      mq[w].delete();
      m_ovf[w] = 1'b0; m_ten[w] = trig_en; m_post[w] = int'(post_count); m_rem[w] = int'(post_count);
      m_state[w] = trig_en ? S_ARMED : S_CAPTURE;
      return;
    end
    nst  = m_state[w];
    live = (m_state[w] == S_ARMED) || (m_state[w] == S_CAPTURE);
    if (mq[w].size() != 0 && rd_ready) mq[w].delete(0);
    if (commit_valid && live) begin
      e = '{pc: commit_pc, instr: commit_instr, rd: commit_rd, we: commit_we, wdata: commit_wdata};
      wrote = 1'b1;
      if (mq[w].size() == DEPTH) begin
        if (m_state[w] == S_ARMED) mq[w].delete(0);
        else begin
          m_ovf[w] = 1'b1;
          if (wrap) mq[w].delete(0);
          else begin
            wrote = 1'b0;
            if (!m_ten[w]) nst = S_DONE;
          end
        end
      end
      if (wrote) mq[w].push_back(e);
      if (m_state[w] == S_ARMED) begin
        if (commit_pc == trig_pc) begin
          m_rem[w] = m_post[w];
          nst = (m_post[w] == 0) ? S_DONE : S_CAPTURE;
        end
      end else if (m_ten[w] && wrote) begin
        m_rem[w]--;
        if (m_rem[w] == 0) nst = S_DONE;
      end
    end
    if (stop && live) nst = S_DONE;
    m_state[w] = nst;
  endtask

  task automatic cmp_one(int w, logic v, logic [CW-1:0] c, logic o, logic [1:0] s, trace_entry_t e);
    check("rd_valid", w, v, mq[w].size() != 0);
    check("count", w, c, mq[w].size());
    check("overflow", w, o, m_ovf[w]);
    check("state", w, s, m_state[w]);
    if (mq[w].size() != 0) check("entry", w, e, mq[w][0]);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_one(0, bw.rd_valid, count_w, ovf_w, st_w,
              '{pc: bw.rd_pc, instr: bw.rd_instr, rd: bw.rd_rd, we: bw.rd_we, wdata: bw.rd_wdata});
      cmp_one(1, bs.rd_valid, count_s, ovf_s, st_s,
              '{pc: bs.rd_pc, instr: bs.rd_instr, rd: bs.rd_rd, we: bs.rd_we, wdata: bs.rd_wdata});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    if (reset_n) begin
      model_step(0, 1'b1);
      model_step(1, 1'b0);
    end
    @(negedge clk);
    #1;
    commit_valid = 1'b0; arm = 1'b0; stop = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic set_commit(logic [31:0] pc);
    commit_valid = 1'b1; commit_pc = pc; commit_instr = $urandom;
    commit_rd = 5'($urandom); commit_we = 1'($urandom); commit_wdata = $urandom;
  endtask

  task automatic do_commit(logic [31:0] pc, bit rdy = 1'b0);
    set_commit(pc);
    rd_ready = rdy;
    tick();
  endtask

  task automatic do_arm(bit te, logic [31:0] tpc, int pc_n);
    arm = 1'b1; trig_en = te; trig_pc = tpc; post_count = CW'(pc_n);
    tick();
  endtask

  task automatic do_pop();
    rd_ready = 1'b1;
    tick();
  endtask

  initial begin
    model_reset();
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    cmp_en = 1'b1;
    check("rst_state", 0, st_w, S_IDLE);
    check("rst_count", 0, count_w, 0);
    check("rst_valid", 0, bw.rd_valid, 0);
    check("rst_ovf", 0, ovf_w, 0);
    reset_n = 1'b1;
    tick();

    // three commits, untriggered
    do_arm(1'b0, 32'h0, 0);
    do_commit(32'h0); do_commit(32'h4); do_commit(32'h8);
    check("t1_count", 0, count_w, 3);
    check("t1_state", 0, st_w, S_CAPTURE);
    for (int i = 0; i < 3; i++) begin
      check("t1_pop_pc", 0, bw.rd_pc, 32'(i * 4));
      do_pop();
    end
    check("t1_empty", 0, bw.rd_valid, 0);

    // 20 commits: wrap instance overwrites, stop instance drops the 17th
    do_arm(1'b0, 32'h0, 0);
    for (int i = 0; i < 20; i++) do_commit(32'(i * 4));
    check("t2_count", 0, count_w, 16);
    check("t2_ovf", 0, ovf_w, 1);
    check("t2_state", 0, st_w, S_CAPTURE);
    check("t2_first", 0, bw.rd_pc, 32'h10);
    check("t3_count", 1, count_s, 16);
    check("t3_ovf", 1, ovf_s, 1);
    check("t3_state", 1, st_s, S_DONE);
    check("t3_first", 1, bs.rd_pc, 32'h0);
    repeat (15) do_pop();
    check("t3_last", 1, bs.rd_pc, 32'h3C);
    check("t2_last", 0, bw.rd_pc, 32'h4C);

    // trigger at 0x20 with two post-trigger entries
    do_arm(1'b1, 32'h20, 2);
    check("t4_armed", 0, st_w, S_ARMED);
    for (int i = 0; i < 12; i++) begin
      do_commit(32'(i * 4));
      if (i == 8) check("t4_capture", 0, st_w, S_CAPTURE);
    end
    check("t4_state", 0, st_w, S_DONE);
    check("t4_count", 0, count_w, 11);
    check("t4_first", 0, bw.rd_pc, 32'h0);
    check("t4_state_s", 1, st_s, S_DONE);
    check("t4_count_s", 1, count_s, 11);

    // full buffer, push together with pop
    do_arm(1'b0, 32'h0, 0);
    for (int i = 0; i < 16; i++) do_commit(32'h100 + 32'(i * 4));
    check("t5_full", 0, count_w, 16);
    check("t5_ovf_before", 0, ovf_w, 0);
    check("t5_oldest", 0, bw.rd_pc, 32'h100);
    do_commit(32'h200, 1'b1);
    check("t5_count", 0, count_w, 16);
    check("t5_ovf", 0, ovf_w, 0);
    check("t5_next", 0, bw.rd_pc, 32'h104);

    // asynchronous reset mid-capture
    do_arm(1'b0, 32'h0, 0);
    for (int i = 0; i < 5; i++) do_commit(32'h300 + 32'(i * 4));
    check("t6_pre_count", 0, count_w, 5);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("t6_count", 0, count_w, 0);
    check("t6_state", 0, st_w, S_IDLE);
    check("t6_valid", 0, bw.rd_valid, 0);
    check("t6_count_s", 1, count_s, 0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) do_commit(32'h400 + 32'(i * 4));
    check("t6_ignored", 0, count_w, 0);
    check("t6_idle", 0, st_w, S_IDLE);

    // randomized session traffic
    for (int c = 0; c < 3000; c++) begin
      int rdy_pct;
      rdy_pct = (((c / 400) % 2) != 0) ? 80 : 20;
      if ($urandom_range(0, 999) < 3) begin
        reset_n = 1'b0;
        model_reset();
        tick();
        reset_n = 1'b1;
      end else begin
        if ($urandom_range(0, 99) < 2) begin
          arm = 1'b1;
          trig_en = 1'($urandom);
          trig_pc = 32'($urandom_range(0, 31) * 4);
          post_count = CW'($urandom_range(0, 20));
        end
        stop = ($urandom_range(0, 99) < 2);
        if ($urandom_range(0, 99) < 60) set_commit(32'($urandom_range(0, 31) * 4));
        rd_ready = ($urandom_range(0, 99) < rdy_pct);
        tick();
      end
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Synthesizable on-chip retire tracer for the RV32I core. It records one entry per retired instruction into a parametrised ring buffer, and supports an optional PC-match trigger with post-trigger depth and full-buffer wrap or stop modes. Captured entries are read out over a valid/ready port. It sits beside the CPU top, fed from the writeback/commit point, and replaces ad-hoc `$monitor` tracing so traces survive into FPGA builds.

## Interface
Parameters:
- XLEN, 32, width of PC and writeback data
- DEPTH, 16, number of entries; power of two, ≥2
- WRAP, 1, behaviour at full in CAPTURE: 1 overwrites the oldest entry, 0 stops at full

Ports:
- clk  in  1  single clock; all state is updated on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- commit_valid  in  1  an instruction retires this cycle
- commit_pc  in  XLEN  PC of the retiring instruction
- commit_instr  in  32  encoding of the retiring instruction
- commit_rd  in  5  destination register
- commit_we  in  1  register-file write enable
- commit_wdata  in  XLEN  writeback value
- arm  in  1  pulse: clear the buffer and start a session
- stop  in  1  pulse: end the session (go to DONE)
- trig_en  in  1  sampled at arm; 1 means wait for a trigger
- trig_pc  in  XLEN  trigger PC
- post_count  in  $clog2(DEPTH)+1  entries recorded after the trigger entry; sampled at arm
- rd_valid  out  1  the oldest entry is available
- rd_ready  in  1  consumer accepts the entry
- rd_pc, rd_instr, rd_rd, rd_we, rd_wdata  out  widths as the commit_* ports  oldest entry fields
- count  out  $clog2(DEPTH)+1  entries held
- overflow  out  1  sticky: an entry was overwritten or dropped since arm
- state  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3

## Operation
- Reset: state=IDLE, all pointers 0, count=0, overflow=0, rd_valid=0.
- arm in any state:
  - clears the pointers, count and overflow;
  - latches trig_en and post_count;
  - next state is ARMED if trig_en=1, else CAPTURE.
  - When arm and stop are asserted in the same cycle, arm wins.
- IDLE and DONE: commits are ignored.
- ARMED:
  - every valid commit is written as pre-trigger history, always in wrap fashion, independent of WRAP; overwrites in ARMED do not set overflow;
  - a commit with commit_pc==trig_pc is written and moves the state to CAPTURE, with remaining=post_count;
  - if post_count=0, the state goes straight to DONE instead.
- CAPTURE with trigger:
  - each write decrements remaining;
  - the write that makes remaining 0 moves the state to DONE;
  - full-buffer handling follows WRAP.
- CAPTURE without trigger: the state runs until stop. When WRAP=0, the first commit arriving while full is dropped, overflow is set, and the state goes to DONE.
- Full plus write in CAPTURE:
  - WRAP=1: overwrite the oldest entry, advance the read pointer, set overflow.
  - WRAP=0: drop the entry, set overflow.
- stop in ARMED or CAPTURE moves the state to DONE. stop in IDLE or DONE is ignored.
- Readout is legal in every state:
  - rd_valid = (count≠0);
  - a pop occurs when rd_valid && rd_ready;
  - a push and a pop in the same cycle leave count unchanged;
  - a push when full together with a pop is a normal push: no overwrite, no overflow.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count saturates at DEPTH.

## Timing
- A write occurs on the clk edge at which commit_valid=1. The entry is visible on rd_* and counted in count from the next cycle.
- rd_* are read combinationally from storage at the read pointer. A pop takes effect at the edge.
- State transitions take effect at the edge following the causing input.
- Reset assertion mid-session takes effect immediately (asynchronous) and discards all entries. Storage contents need no reset.

## Structure
- Package trace_pkg:
  - the state encoding (IDLE/ARMED/CAPTURE/DONE);
  - a packed entry struct {pc, instr, rd, we, wdata};
  - the state width constant.
- Sub-module trace_ring:
  - entry storage, read/write pointers and count;
  - push, push_overwrite and pop inputs;
  - full and empty outputs.
- The top level holds the FSM, the trigger compare, the post-trigger counter and the overflow flag.

## Test plan
- Reset, then arm with trig_en=0 and WRAP=1, then 3 commits (pc 0,4,8) → count=3, state=CAPTURE. Pops return pc 0,4,8 in order, then rd_valid=0.
- DEPTH=16, WRAP=1, no trigger, 20 commits (pc 0..76 step 4) → count=16, overflow=1, first pop pc=0x10.
- DEPTH=16, WRAP=0, no trigger, 17 commits → the 17th is dropped, overflow=1, state=DONE, last entry pc=0x3C.
- trig_en=1, trig_pc=0x20, post_count=2, 12 commits pc 0..0x2C → state=DONE after the pc 0x28 write, pc 0x2C ignored, count=11, first pop pc=0.
- With count=16 (full) and state=CAPTURE, WRAP=1: commit and rd_ready in the same cycle → count stays 16, overflow unchanged, popped entry is the oldest.
- Reset_n asserted mid-CAPTURE with count=5 → count=0, state=IDLE, rd_valid=0 immediately. Commits after release are ignored until arm.
